parity_frame_checker: RTL and testbench

Streaming, parametrised parity checker for DATA_W-bit words, each carrying one parity bit. Each accepted word is checked against the selected parity sense (odd or even). A frame of FRAME_LEN words is accumulated, and a per-frame report is produced over a valid/ready handshake. The block sits between a word source (link deserialiser or bus capture) and the status/error logic, and keeps a saturating running count of bad words.

---
 rtl/parity_frame_checker.sv | 123 ++++++++++++
 tb/tb_parity_frame_checker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_checker.sv
// Streaming per-word parity checker that accumulates FRAME_LEN words into a
// frame report (bad-word count, column parity) and keeps a saturating error count.
module parity_frame_checker #(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = 8,
    localparam int BW_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              odd_mode,
    input  logic              clr_cnt,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_parity,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_frame_err,
    output logic [BW_W-1:0]   out_bad_words,
    output logic [DATA_W-1:0] out_col_parity,
    output logic              out_mode,
    output logic              word_err,
    output logic [CNT_W-1:0]  err_count
);

    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] col_acc_q;
    logic [BW_W-1:0]   bad_acc_q;
    logic              mode_q;

    logic              accept;
    logic              mode_now;
    logic              bad;
    logic              last;
    logic [BW_W-1:0]   bad_total;

    assign in_ready  = (state_q == ACCUM);
    assign accept    = in_valid && in_ready;
    // The first word of a frame checks against the live odd_mode, later words against the latched one.
    assign mode_now  = (idx_q == '0) ? odd_mode : mode_q;
    assign bad       = accept && ((^in_data ^ in_parity) != mode_now);
    assign last      = (idx_q == LAST_IDX);
    assign bad_total = bad_acc_q + BW_W'(bad);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (accept && last) state_d = REPORT;
            REPORT:  if (out_ready)      state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q          <= '0;
            col_acc_q      <= '0;
            bad_acc_q      <= '0;
            mode_q         <= 1'b0;
            out_valid      <= 1'b0;
            out_frame_err  <= 1'b0;
            out_bad_words  <= '0;
            out_col_parity <= '0;
            out_mode       <= 1'b0;
        end else begin
            if (accept) begin
                if (idx_q == '0) begin
                    mode_q <= odd_mode;
                end
                if (last) begin
                    idx_q          <= '0;
                    col_acc_q      <= '0;
                    bad_acc_q      <= '0;
                    out_valid      <= 1'b1;
                    out_frame_err  <= (bad_total != '0);
                    out_bad_words  <= bad_total;
                    out_col_parity <= col_acc_q ^ in_data;
                    out_mode       <= mode_now;
                end else begin
                    idx_q     <= idx_q + IDX_W'(1);
                    col_acc_q <= col_acc_q ^ in_data;
                    bad_acc_q <= bad_total;
                end
            end else if (state_q == REPORT && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_err  <= 1'b0;
            err_count <= '0;
        end else begin
            word_err <= bad;
            if (clr_cnt) begin
                err_count <= CNT_W'(bad);
            end else if (bad && (err_count != '1)) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker: a FRAME_LEN=4 instance for the main
// frame scenarios and a FRAME_LEN=1, CNT_W=2 instance for counter saturation.
module tb_parity_frame_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       odd_mode;
    logic       clr_cnt;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_parity;
    logic       out_valid;
    logic       out_ready;
    logic       out_frame_err;
    logic [2:0] out_bad_words;
    logic [7:0] out_col_parity;
    logic       out_mode;
    logic       word_err;
    logic [7:0] err_count;

    logic       s_valid;
    logic       s_ready;
    logic       s_out_valid;
    logic       s_frame_err;
    logic       s_bad_words;
    logic [7:0] s_col_parity;
    logic       s_mode;
    logic       s_word_err;
    logic [1:0] s_err_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    parity_frame_checker #(.DATA_W(8), .FRAME_LEN(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .odd_mode(odd_mode), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_parity(in_parity), .out_valid(out_valid), .out_ready(out_ready),
        .out_frame_err(out_frame_err), .out_bad_words(out_bad_words),
        .out_col_parity(out_col_parity), .out_mode(out_mode),
        .word_err(word_err), .err_count(err_count)
    );

    parity_frame_checker #(.DATA_W(8), .FRAME_LEN(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .odd_mode(odd_mode), .clr_cnt(clr_cnt),
        .in_valid(s_valid), .in_ready(s_ready), .in_data(in_data),
        .in_parity(in_parity), .out_valid(s_out_valid), .out_ready(1'b1),
        .out_frame_err(s_frame_err), .out_bad_words(s_bad_words),
        .out_col_parity(s_col_parity), .out_mode(s_mode),
        .word_err(s_word_err), .err_count(s_err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one word on the falling edge; it is accepted on the next rising edge.
    task automatic send(input logic [7:0] d, input logic p, input bit sat);
        @(negedge clk);
        in_data   = d;
        in_parity = p;
        if (sat) s_valid = 1'b1; else in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        s_valid  = 1'b0;
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic chk_report(input string tag, input logic err, input logic [2:0] bw,
                              input logic [7:0] col, input logic md);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_ferr"},  32'(out_frame_err), 32'(err));
        chk({tag, "_bad"},   32'(out_bad_words), 32'(bw));
        chk({tag, "_col"},   32'(out_col_parity), 32'(col));
        chk({tag, "_mode"},  32'(out_mode), 32'(md));
    endtask

    initial begin
        rst_n = 1'b0; odd_mode = 1'b1; clr_cnt = 1'b0; in_valid = 1'b0;
        s_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_parity = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        // Odd mode, all good words
        odd_mode = 1'b1;
        send(8'h01, 1'b0, 0);
        send(8'h03, 1'b1, 0);
        send(8'hFF, 1'b1, 0);
        chk("f1_not_yet", 32'(out_valid), 32'd0);
        send(8'h00, 1'b1, 0);
        chk_report("f1", 1'b0, 3'd0, 8'hFD, 1'b1);
        chk("f1_errcnt", 32'(err_count), 32'd0);
        handshake();
        chk("f1_done_valid", 32'(out_valid), 32'd0);
        chk("f1_done_ready", 32'(in_ready), 32'd1);

        // Even mode, words 1 and 4 bad
        odd_mode = 1'b0;
        send(8'h01, 1'b0, 0);
        chk("f2_werr1", 32'(word_err), 32'd1);
        send(8'h03, 1'b0, 0);
        chk("f2_werr2", 32'(word_err), 32'd0);
        send(8'h07, 1'b1, 0);
        chk("f2_werr3", 32'(word_err), 32'd0);
        send(8'h80, 1'b0, 0);
        chk("f2_werr4", 32'(word_err), 32'd1);
        chk_report("f2", 1'b1, 3'd2, 8'h85, 1'b0);
        chk("f2_errcnt", 32'(err_count), 32'd2);

        // Backpressure: report held, offered words ignored
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h55; in_parity = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_ready", 32'(in_ready), 32'd0);
            chk("bp_col", 32'(out_col_parity), 32'h85);
            chk("bp_errcnt", 32'(err_count), 32'd2);
        end
        in_valid = 1'b0;
        handshake();
        chk("bp_done_valid", 32'(out_valid), 32'd0);
        chk("bp_word_err", 32'(word_err), 32'd0);

        // Mode latched at word 1; clear coincides with the bad last word
        odd_mode = 1'b1;
        send(8'h01, 1'b0, 0);
        odd_mode = 1'b0;
        send(8'h02, 1'b0, 0);
        chk("f3_latched_werr", 32'(word_err), 32'd0);
        send(8'h04, 1'b0, 0);
        clr_cnt = 1'b1;
        send(8'h08, 1'b1, 0);
        clr_cnt = 1'b0;
        chk("f3_clr_bad", 32'(err_count), 32'd1);
        chk_report("f3", 1'b1, 3'd1, 8'h0F, 1'b1);
        @(negedge clk);
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        chk("clr_only", 32'(err_count), 32'd0);
        handshake();

        // Reset mid-frame discards the partial frame
        odd_mode = 1'b1;
        send(8'h01, 1'b1, 0);
        send(8'h10, 1'b0, 0);
        chk("pre_rst_errcnt", 32'(err_count), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_errcnt", 32'(err_count), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        chk("arst_col", 32'(out_col_parity), 32'd0);
        chk("arst_mode", 32'(out_mode), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h11, 1'b1, 0);
        send(8'h22, 1'b1, 0);
        chk("f4_mid_valid", 32'(out_valid), 32'd0);
        send(8'h44, 1'b1, 0);
        chk("f4_mid3_valid", 32'(out_valid), 32'd0);
        send(8'h0F, 1'b1, 0);
        chk_report("f4", 1'b0, 3'd0, 8'h78, 1'b1);
        handshake();

        // FRAME_LEN=1, CNT_W=2: every word reports, counter saturates at 3
        odd_mode = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            send(8'h00, 1'b0, 1);
            chk("sat_valid", 32'(s_out_valid), 32'd1);
            chk("sat_bad", 32'(s_bad_words), 32'd1);
            chk("sat_cnt", 32'(s_err_count), (i > 3) ? 32'd3 : 32'(i));
            @(posedge clk);
            #1;
            chk("sat_ready_back", 32'(s_ready), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
